// File: rtl/arb_mux_reg.sv
// N-channel arbitrated multiplexer with a single registered output beat.
// Round-robin (MODE=0) or fixed-priority (MODE=1) selection, valid/ready on all sides.
module arb_mux_reg #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel
);

  logic [SELW-1:0]  ptr_r;
  logic [SELW-1:0]  ptr_nxt_s;
  logic [SELW-1:0]  gsel_s;
  logic [WIDTH-1:0] gdata_s;
  logic [N-1:0]     grant_s;
  logic             found_s;
  logic             hit_s;
  logic             can_load_s;
  int               base_s;
  int               dist_s;
  int               best_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SELW-1:0]  out_sel_r;

  // Grant search: each requester's distance from the search start; the nearest valid one wins.
  always_comb begin
    base_s  = (MODE == 0) ? int'(ptr_r) : 0;
    best_s  = N;
    dist_s  = 0;
    hit_s   = 1'b0;
    gsel_s  = {SELW{1'b0}};
    gdata_s = {WIDTH{1'b0}};
    grant_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      dist_s  = (i >= base_s) ? (i - base_s) : (i + N - base_s);
      hit_s   = in_valid[i] && (dist_s < best_s);
      best_s  = hit_s ? dist_s : best_s;
      gsel_s  = hit_s ? SELW'(i) : gsel_s;
      gdata_s = hit_s ? in_data[i*WIDTH +: WIDTH] : gdata_s;
    end
    found_s = (best_s < N);
    for (int i = 0; i < N; i++) begin
      grant_s[i] = found_s && (gsel_s == SELW'(i));
    end
  end

  assign can_load_s = !out_valid_r || out_ready;
  assign in_ready   = grant_s & {N{can_load_s}} & ~{N{rst}};
  // Pointer moves one past the winner, wrapping explicitly so non-power-of-two N works.
  assign ptr_nxt_s  = (MODE != 0) ? {SELW{1'b0}} :
                      (gsel_s == SELW'(N - 1)) ? {SELW{1'b0}} : gsel_s + 1'b1;

  // Output beat register and arbitration pointer; a load wins over a drain so there is no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_sel_r   <= {SELW{1'b0}};
      ptr_r       <= {SELW{1'b0}};
    end else if (|in_ready) begin
      out_valid_r <= 1'b1;
      out_data_r  <= gdata_s;
      out_sel_r   <= gsel_s;
      ptr_r       <= ptr_nxt_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Randomized scoreboard bench for arb_mux_reg: three instances (N=4 RR, N=4 priority, N=3 RR),
// exercised one at a time against a queue-based reference model.
module tb_arb_mux_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        rst_v = 3'b111;
  logic [2:0][3:0]   iv    = '0;
  logic [2:0][255:0] idat  = '0;
  logic [2:0]        ordy  = 3'b000;

  logic [3:0]  irdy_a, irdy_b;
  logic [2:0]  irdy_c;
  logic        ovld_a, ovld_b, ovld_c;
  logic [63:0] odat_a, odat_b, odat_c;
  logic [1:0]  osel_a, osel_b, osel_c;

  arb_mux_reg #(.WIDTH(64), .N(4), .MODE(0)) u_rr4 (
    .clk(clk), .rst(rst_v[0]), .in_valid(iv[0]), .in_ready(irdy_a), .in_data(idat[0]),
    .out_valid(ovld_a), .out_ready(ordy[0]), .out_data(odat_a), .out_sel(osel_a));

  arb_mux_reg #(.WIDTH(64), .N(4), .MODE(1)) u_fp4 (
    .clk(clk), .rst(rst_v[1]), .in_valid(iv[1]), .in_ready(irdy_b), .in_data(idat[1]),
    .out_valid(ovld_b), .out_ready(ordy[1]), .out_data(odat_b), .out_sel(osel_b));

  arb_mux_reg #(.WIDTH(64), .N(3), .MODE(0)) u_rr3 (
    .clk(clk), .rst(rst_v[2]), .in_valid(iv[2][2:0]), .in_ready(irdy_c), .in_data(idat[2][191:0]),
    .out_valid(ovld_c), .out_ready(ordy[2]), .out_data(odat_c), .out_sel(osel_c));

  int cur = 0;
  int nch = 4;
  int mode = 0;
  int n_tests = 0;
  int n_fail = 0;

  logic [3:0]  cur_rdy;
  logic        cur_vld;
  logic [63:0] cur_dat;
  logic [1:0]  cur_sel;

  // View of whichever instance is under test
  always_comb begin
    case (cur)
      0:       begin cur_rdy = irdy_a;         cur_vld = ovld_a; cur_dat = odat_a; cur_sel = osel_a; end
      1:       begin cur_rdy = irdy_b;         cur_vld = ovld_b; cur_dat = odat_b; cur_sel = osel_b; end
      default: begin cur_rdy = {1'b0, irdy_c}; cur_vld = ovld_c; cur_dat = odat_c; cur_sel = osel_c; end
    endcase
  end

  // Reference state: is a beat held, where the next round-robin search starts, queued beats {sel,data}
  bit          mod_valid = 1'b0;
  int          mod_ptr = 0;
  bit [65:0]   exp_q[$];
  logic [63:0] chan_data [4];
  bit          fixed_data = 1'b1;
  bit          prev_rst = 1'b0;
  logic [3:0]  last_acc = 4'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (unit %0d, t=%0t): got %h, expected %h", nm, cur, $time, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] v, input bit r, input bit rs);
    int g;
    bit can;
    logic [3:0] exp_rdy;
    @(negedge clk);
    iv[cur]    = v;
    ordy[cur]  = r;
    rst_v[cur] = rs;
    for (int i = 0; i < 4; i++) idat[cur][i*64 +: 64] = chan_data[i];
    #1;
    chk("out_valid", {63'b0, cur_vld}, {63'b0, mod_valid});
    if (mod_valid && exp_q.size() > 0) begin
      chk("held_data", cur_dat, exp_q[0][63:0]);
      chk("held_sel", {62'b0, cur_sel}, {62'b0, exp_q[0][65:64]});
    end
    if (prev_rst) begin
      chk("reset_data", cur_dat, 64'h0);
      chk("reset_sel", {62'b0, cur_sel}, 64'h0);
    end
    g = -1;
    for (int k = 0; k < nch; k++) begin
      int c;
      c = ((mode != 0 ? 0 : mod_ptr) + k) % nch;
      if (g < 0 && v[c]) g = c;
    end
    can = !mod_valid || r;
    exp_rdy = (g >= 0 && can && !rs) ? 4'(1 << g) : 4'b0;
    chk("in_ready", {60'b0, cur_rdy}, {60'b0, exp_rdy});
    last_acc = exp_rdy;
    if (rs) begin
      mod_valid = 1'b0;
      mod_ptr   = 0;
      exp_q.delete();
    end else if (exp_rdy != 4'b0) begin
      exp_q.push_back({2'(g), chan_data[g]});
      mod_valid = 1'b1;
      if (mode == 0) mod_ptr = (g + 1) % nch;
      if (!fixed_data) chan_data[g] = {$urandom, $urandom};
    end else if (r) begin
      mod_valid = 1'b0;
    end
    prev_rst = rs;
  endtask

  task automatic select_unit(input int u, input int n, input int m);
    rst_v[cur] = 1'b1;
    cur  = u;
    nch  = n;
    mode = m;
    mod_valid = 1'b0;
    mod_ptr   = 0;
    exp_q.delete();
  endtask

  task automatic rand_phase(input int cycles);
    logic [3:0] pend;
    logic [3:0] mask;
    pend = 4'b0;
    mask = (nch == 4) ? 4'hF : 4'h7;
    fixed_data = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      pend = pend | (4'($urandom) & mask);
      step(pend, $urandom_range(3, 0) != 0, $urandom_range(49, 0) == 0);
      pend = pend & ~last_acc;
    end
    step(4'b0, 1'b1, 1'b0);
    step(4'b0, 1'b1, 1'b0);
  endtask

  // Monitor: every output transfer must match the oldest expected beat
  initial begin
    bit [65:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_v[cur] && cur_vld && ordy[cur]) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat (unit %0d, t=%0t): got sel %0d data %h, expected none",
                   cur, $time, cur_sel, cur_dat);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", cur_dat, e[63:0]);
          chk("beat_sel", {62'b0, cur_sel}, {62'b0, e[65:64]});
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) chan_data[i] = 64'h1000 + 64'(i);

    // Round-robin N=4: reset with everything asserted, fairness, backpressure, reset in a stall
    select_unit(0, 4, 0);
    step(4'hF, 1'b1, 1'b1);
    step(4'hF, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(4'hF, 1'b1, 1'b0);
    chan_data[2] = 64'hDEAD;
    step(4'b0100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'hF, 1'b0, 1'b0);
    step(4'hF, 1'b1, 1'b0);
    step(4'hF, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b1);
    step(4'hF, 1'b1, 1'b0);
    step(4'hF, 1'b1, 1'b0);
    rand_phase(300);

    // Fixed priority N=4: channel 3 starved until channel 1 drops
    select_unit(1, 4, 1);
    fixed_data = 1'b1;
    for (int i = 0; i < 4; i++) chan_data[i] = 64'h2000 + 64'(i);
    step(4'hF, 1'b1, 1'b1);
    step(4'hF, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b1010, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    rand_phase(300);

    // Round-robin N=3: only channels 0 and 2 valid, wrap from 2 back to 0
    select_unit(2, 3, 0);
    fixed_data = 1'b1;
    for (int i = 0; i < 4; i++) chan_data[i] = 64'h3000 + 64'(i);
    step(4'h7, 1'b1, 1'b1);
    step(4'h7, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0101, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    rand_phase(300);

    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
